wb_write_queue: RTL and testbench
=================================

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning queue entries; legal values 2..16.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 mem_valid / mem_addr / mem_data  in  1/5/32  load-result write request (older source).
REQ-005 mem_ready  out  1  mem request accepted this cycle when mem_valid&mem_ready.
REQ-006 alu_valid / alu_addr / alu_data  in  1/5/32  ALU-result write request (younger source).
REQ-007 alu_ready  out  1  alu request accepted this cycle when alu_valid&alu_ready.
REQ-008 hold  in  1  pause draining while high.
REQ-009 rf_reg_write / rf_write_addr / rf_write_data  out  1/5/32  registered write port driving the register file.
REQ-010 lookup_addr  in  5  register number to query for a pending write.
REQ-011 lookup_hit / lookup_data  out  1/32  combinational pending-write match and value.
REQ-012 count  out  5  occupied queue entries, excluding the rf_* output stage.

Function
REQ-013 The queue SHALL be a circular FIFO of DEPTH {addr, data} entries, with head/tail pointers wrapping modulo DEPTH.
REQ-014 free = DEPTH - count, sampled at the start of the cycle; a same-cycle pop SHALL NOT add space.
REQ-015 mem_ready SHALL be (free >= 1); alu_ready SHALL be (free >= (mem_valid ? 2 : 1)).
REQ-016 If both are accepted in one cycle, the mem entry SHALL be enqueued ahead of the alu entry.
REQ-017 An accepted request with addr = 0 SHALL complete the handshake but SHALL NOT be enqueued, and count SHALL NOT change for it.
REQ-018 Each cycle with hold = 0 and count > 0, the head SHALL be popped; rf_reg_write<=1, rf_write_addr<=head.addr and rf_write_data<=head.data at that edge.
REQ-019 Otherwise rf_reg_write SHALL be 0 for the next cycle, and rf_write_addr/data SHALL hold their values.
REQ-020 Latency: an entry accepted at edge N into an empty queue with hold = 0 SHALL appear on rf_* after edge N+1; throughput is 1 write/cycle.
REQ-021 hold asserted SHALL stop popping; enqueue SHALL continue until full.
REQ-022 On a full queue, both readies SHALL be 0; a pop in the same cycle SHALL NOT make a ready high.
REQ-023 count SHALL update as count + pushes - pop, and SHALL never exceed DEPTH or underflow.
REQ-024 Lookup SHALL search the queue entries and the rf_* stage when rf_reg_write = 1, and return the youngest match (tail-most queue entry, then rf_* stage).
REQ-025 Same-cycle incoming requests SHALL NOT take part in lookup.
REQ-026 lookup_addr = 0 SHALL give lookup_hit = 0; with no match, lookup_data SHALL be 0.

Reset
REQ-027 When rst is high, head, tail and count SHALL be 0, and rf_reg_write, rf_write_addr and rf_write_data SHALL be 0, regardless of clk.
REQ-028 Queue contents SHALL be discarded by reset mid-operation; no rf write SHALL issue in the first cycle after rst falls.
REQ-029 During reset, mem_ready and alu_ready SHALL reflect an empty queue, but no request SHALL be accepted while rst is high.

Configuration
REQ-030 With macro WBQ_FORWARD_EN defined, the lookup logic in REQ-024..026 SHALL be built.
REQ-031 Without WBQ_FORWARD_EN, lookup_hit and lookup_data SHALL be tied to 0; the ports SHALL remain; all other behaviour SHALL be unchanged.

Verification
REQ-032 Single write, idle queue: mem_valid, addr 5, data 0x1234 at edge 1 -> rf_reg_write=1, addr 5, data 0x1234 after edge 2; count returns to 0.
REQ-033 Dual push: mem {3,0xAAAA} and alu {3,0xBBBB} in the same cycle -> rf writes to r3 in order 0xAAAA then 0xBBBB; lookup_addr=3 returns 0xBBBB while both are pending.
REQ-034 Fill with hold=1: 4 alu pushes {1..4, 0x10..0x40} -> count=4, both readies 0; release hold -> 4 consecutive writes in order; wraparound checked with 6 more pushes.
REQ-035 r0 drop: alu {0,0xDEAD} accepted -> count stays 0, no rf_reg_write; lookup_addr=0 gives hit 0.
REQ-036 Ready gating: count=3 (DEPTH 4), mem_valid=alu_valid=1 -> mem_ready=1, alu_ready=0; only the mem entry is enqueued.
REQ-037 Reset mid-operation: count=3 with hold=1, pulse rst asynchronously between edges -> outputs 0 immediately; no writes after release. Repeat all scenarios with and without WBQ_FORWARD_EN.

Source files
------------

// File: rtl/wb_write_queue.sv
// -----------------------------------------------------------------------------
// wb_write_queue
//   Write-back queue that merges two register-file write sources (an older
//   load-result source "mem" and a younger ALU-result source "alu") into a
//   single registered register-file write port.
//
//   Accepted writes are buffered in a circular FIFO of DEPTH entries and are
//   drained one per cycle while hold is low. Writes to r0 complete their
//   handshake but are discarded. An optional lookup port reports the youngest
//   pending write to a given register (queue entries, then the rf_* stage).
//
// Configuration macro:
//   WBQ_FORWARD_EN : when defined, the lookup (forwarding) logic is built;
//                    when undefined, lookup_hit/lookup_data are tied to 0.
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst            in   1   asynchronous, active-high reset
//   mem_valid      in   1   load-result write request
//   mem_addr       in   5   load-result destination register
//   mem_data       in  32   load-result value
//   mem_ready      out  1   mem request accepted when mem_valid & mem_ready
//   alu_valid      in   1   ALU-result write request
//   alu_addr       in   5   ALU-result destination register
//   alu_data       in  32   ALU-result value
//   alu_ready      out  1   alu request accepted when alu_valid & alu_ready
//   hold           in   1   pause draining while high
//   rf_reg_write   out  1   registered register-file write enable
//   rf_write_addr  out  5   registered register-file write address
//   rf_write_data  out 32   registered register-file write data
//   lookup_addr    in   5   register number to query
//   lookup_hit     out  1   a pending write to lookup_addr exists
//   lookup_data    out 32   value of the youngest pending write (0 if none)
//   count          out  5   occupied queue entries (rf_* stage excluded)
// -----------------------------------------------------------------------------
module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        hold,
    output logic        rf_reg_write,
    output logic [4:0]  rf_write_addr,
    output logic [31:0] rf_write_data,
    input  logic [4:0]  lookup_addr,
    output logic        lookup_hit,
    output logic [31:0] lookup_data,
    output logic [4:0]  count
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    // Circular-pointer increment that wraps at DEPTH (DEPTH need not be 2^n).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(DEPTH - 1)) begin
            r = '0;
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    logic [4:0]    addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [4:0]    count_q, count_d;

    logic          rf_reg_write_q;
    logic [4:0]    rf_addr_q;
    logic [31:0]   rf_data_q;

    logic [4:0]    free_s;
    logic          mem_push_s;
    logic          alu_push_s;
    logic          pop_s;
    logic [PW-1:0] alu_slot_s;

    // Free space is taken from the registered count only, so a pop in the
    // same cycle never opens a slot for an incoming request.
    assign free_s    = DEPTH_C - count_q;
    assign mem_ready = (free_s >= 5'd1);
    // The alu source is younger: it may only go in if the mem request (when
    // present) also fits ahead of it.
    assign alu_ready = (free_s >= (mem_valid ? 5'd2 : 5'd1));

    // r0 writes complete the handshake but never occupy an entry.
    assign mem_push_s = mem_valid & mem_ready & (mem_addr != 5'd0);
    assign alu_push_s = alu_valid & alu_ready & (alu_addr != 5'd0);
    assign pop_s      = ~hold & (count_q != 5'd0);

    // Next-state for pointers and occupancy; mem lands before alu.
    always_comb begin
        alu_slot_s = tail_q;
        tail_d     = tail_q;
        head_d     = head_q;
        if (mem_push_s) begin
            alu_slot_s = ptr_inc(tail_q);
        end else begin
            alu_slot_s = tail_q;
        end
        if (alu_push_s) begin
            tail_d = ptr_inc(alu_slot_s);
        end else begin
            tail_d = alu_slot_s;
        end
        if (pop_s) begin
            head_d = ptr_inc(head_q);
        end else begin
            head_d = head_q;
        end
        count_d = count_q + {4'd0, mem_push_s} + {4'd0, alu_push_s} - {4'd0, pop_s};
    end

    // Pointer, occupancy and rf output-stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= 5'd0;
            rf_reg_write_q <= 1'b0;
            rf_addr_q      <= 5'd0;
            rf_data_q      <= 32'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (pop_s) begin
                rf_reg_write_q <= 1'b1;
                rf_addr_q      <= addr_q[head_q];
                rf_data_q      <= data_q[head_q];
            end else begin
                rf_reg_write_q <= 1'b0;
            end
        end
    end

    // Entry storage; contents are meaningless outside head..tail so no reset.
    always_ff @(posedge clk) begin
        if (mem_push_s) begin
            addr_q[tail_q] <= mem_addr;
            data_q[tail_q] <= mem_data;
        end
        if (alu_push_s) begin
            addr_q[alu_slot_s] <= alu_addr;
            data_q[alu_slot_s] <= alu_data;
        end
    end

    assign rf_reg_write  = rf_reg_write_q;
    assign rf_write_addr = rf_addr_q;
    assign rf_write_data = rf_data_q;
    assign count         = count_q;

`ifdef WBQ_FORWARD_EN
    logic        lookup_hit_s;
    logic [31:0] lookup_data_s;
    logic [4:0]  lk_slot_s;

    // Youngest-match search: rf stage first (oldest), then queue entries from
    // head to tail so later matches overwrite earlier ones.
    always_comb begin
        lookup_hit_s  = 1'b0;
        lookup_data_s = 32'd0;
        lk_slot_s     = 5'd0;
        if (lookup_addr != 5'd0) begin
            if (rf_reg_write_q && (rf_addr_q == lookup_addr)) begin
                lookup_hit_s  = 1'b1;
                lookup_data_s = rf_data_q;
            end else begin
                lookup_hit_s  = 1'b0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                lk_slot_s = 5'(head_q) + 5'(i);
                if (lk_slot_s >= DEPTH_C) begin
                    lk_slot_s = lk_slot_s - DEPTH_C;
                end else begin
                    lk_slot_s = lk_slot_s;
                end
                if ((5'(i) < count_q) && (addr_q[lk_slot_s[PW-1:0]] == lookup_addr)) begin
                    lookup_hit_s  = 1'b1;
                    lookup_data_s = data_q[lk_slot_s[PW-1:0]];
                end else begin
                    lookup_hit_s  = lookup_hit_s;
                end
            end
        end else begin
            lookup_hit_s  = 1'b0;
            lookup_data_s = 32'd0;
        end
    end

    assign lookup_hit  = lookup_hit_s;
    assign lookup_data = lookup_data_s;
`else
    logic lookup_unused_s;

    assign lookup_unused_s = ^lookup_addr;
    assign lookup_hit      = 1'b0;
    assign lookup_data     = 32'd0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_write_queue
//   Self-checking bench for wb_write_queue. A reference model (SV queue of
//   pending {addr,data} entries plus the rf output stage) predicts readies,
//   count, rf outputs and lookup results each cycle. Accepted writes are also
//   pushed to a scoreboard that a separate monitor drains whenever the DUT
//   asserts rf_reg_write.
// -----------------------------------------------------------------------------
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        hold;
    logic        rf_reg_write;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic [4:0]  lookup_addr;
    logic        lookup_hit;
    logic [31:0] lookup_data;
    logic [4:0]  count;

    int n_cmp;
    int n_err;

    ent_t        mq[$];
    ent_t        exp_q[$];
    bit          rf_v;
    logic [4:0]  rf_a;
    logic [31:0] rf_d;

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .alu_valid    (alu_valid),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .hold         (hold),
        .rf_reg_write (rf_reg_write),
        .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data),
        .lookup_addr  (lookup_addr),
        .lookup_hit   (lookup_hit),
        .lookup_data  (lookup_data),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance model.
    task automatic step(input bit mv, input logic [4:0] ma, input logic [31:0] md,
                        input bit av, input logic [4:0] aa, input logic [31:0] ad,
                        input bit hd, input logic [4:0] la);
        int          free;
        bit          mr;
        bit          ar;
        bit          lh;
        logic [31:0] ld;
        ent_t        e;
        @(negedge clk);
        mem_valid   = mv;
        mem_addr    = ma;
        mem_data    = md;
        alu_valid   = av;
        alu_addr    = aa;
        alu_data    = ad;
        hold        = hd;
        lookup_addr = la;
        #1;
        free = DEPTH - mq.size();
        mr   = (free >= 1);
        ar   = (free >= (mv ? 2 : 1));
        chk("count", 32'(count), 32'(mq.size()));
        chk("mem_ready", 32'(mem_ready), 32'(mr));
        chk("alu_ready", 32'(alu_ready), 32'(ar));
        chk("rf_reg_write", 32'(rf_reg_write), 32'(rf_v));
        chk("rf_write_addr", 32'(rf_write_addr), 32'(rf_a));
        chk("rf_write_data", rf_write_data, rf_d);
        lh = 1'b0;
        ld = 32'd0;
`ifdef WBQ_FORWARD_EN
        if (la != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!lh && mq[i].a == la) begin
                    lh = 1'b1;
                    ld = mq[i].d;
                end
            end
            if (!lh && rf_v && rf_a == la) begin
                lh = 1'b1;
                ld = rf_d;
            end
        end
`endif
        chk("lookup_hit", 32'(lookup_hit), 32'(lh));
        chk("lookup_data", lookup_data, ld);
        // model advance: pop uses pre-edge occupancy, then mem before alu
        if (!hd && mq.size() > 0) begin
            e    = mq.pop_front();
            rf_v = 1'b1;
            rf_a = e.a;
            rf_d = e.d;
        end else begin
            rf_v = 1'b0;
        end
        if (mv && mr && ma != 5'd0) begin
            e.a = ma;
            e.d = md;
            mq.push_back(e);
            exp_q.push_back(e);
        end
        if (av && ar && aa != 5'd0) begin
            e.a = aa;
            e.d = ad;
            mq.push_back(e);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit hd, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, hd, 5'd0);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic mid_reset();
        @(negedge clk);
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        hold      = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_rf_reg_write", 32'(rf_reg_write), 32'd0);
        chk("rst_rf_write_addr", 32'(rf_write_addr), 32'd0);
        chk("rst_rf_write_data", rf_write_data, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        mq.delete();
        exp_q.delete();
        rf_v = 1'b0;
        rf_a = 5'd0;
        rf_d = 32'd0;
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every DUT write must match the oldest expected one.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (!rst && rf_reg_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_write", 32'(rf_reg_write), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_addr", 32'(rf_write_addr), 32'(e.a));
                    chk("sb_data", rf_write_data, e.d);
                end
            end
        end
    end

    initial begin
        logic [31:0] exp_lk;
        n_cmp       = 0;
        n_err       = 0;
        rf_v        = 1'b0;
        rf_a        = 5'd0;
        rf_d        = 32'd0;
        rst         = 1'b1;
        mem_valid   = 1'b0;
        mem_addr    = 5'd0;
        mem_data    = 32'd0;
        alu_valid   = 1'b0;
        alu_addr    = 5'd0;
        alu_data    = 32'd0;
        hold        = 1'b0;
        lookup_addr = 5'd0;
        #3;
        chk("init_rf_reg_write", 32'(rf_reg_write), 32'd0);
        chk("init_rf_write_data", rf_write_data, 32'd0);
        chk("init_count", 32'(count), 32'd0);
        chk("init_mem_ready", 32'(mem_ready), 32'd1);
        chk("init_alu_ready", 32'(alu_ready), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;

        // single write into an idle queue: visible on rf_* after the second edge
        step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5);
        chk("single_we", 32'(rf_reg_write), 32'd1);
        chk("single_addr", 32'(rf_write_addr), 32'd5);
        chk("single_data", rf_write_data, 32'h1234);
        chk("single_count", 32'(count), 32'd0);
        idle(1'b0, 2);

        // dual push to the same register: mem first, lookup sees the alu value
        step(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'hBBBB, 1'b1, 5'd3);
`ifdef WBQ_FORWARD_EN
        exp_lk = 32'hBBBB;
`else
        exp_lk = 32'd0;
`endif
        chk("dual_lookup", lookup_data, exp_lk);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3);
        idle(1'b0, 1);

        // fill under hold, check full, release and drain, then wrap
        for (int i = 1; i <= 4; i++)
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'(16 * i), 1'b1, 5'(i));
        chk("full_count", 32'(count), 32'd4);
        chk("full_alu_ready", 32'(alu_ready), 32'd0);
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd2);
        idle(1'b0, 5);
        for (int i = 0; i < 6; i++)
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(11 + i), 32'h100 + 32'(i), 1'b0, 5'(11 + i));
        idle(1'b0, 3);

        // r0 write is accepted and dropped
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("r0_count", 32'(count), 32'd0);
        chk("r0_we", 32'(rf_reg_write), 32'd0);
        chk("r0_hit", 32'(lookup_hit), 32'd0);

        // ready gating with one slot left: only mem goes in
        for (int i = 1; i <= 3; i++)
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'h300 + 32'(i), 1'b1, 5'd0);
        step(1'b1, 5'd6, 32'h600, 1'b1, 5'd7, 32'h700, 1'b1, 5'd7);
        chk("gate_count", 32'(count), 32'd4);
        idle(1'b0, 6);

        // asynchronous reset with three entries pending under hold
        for (int i = 1; i <= 3; i++)
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 20), 32'h500 + 32'(i), 1'b1, 5'd0);
        mid_reset();
        idle(1'b0, 4);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 7)));
        end

        idle(1'b0, DEPTH + 3);
        @(negedge clk);
        #1;
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
